// File: rtl/digit_counter.sv
// Two-digit hex/BCD up/down counter advanced by a free-running clock prescaler.
// Digits, tick and tc are registered; priority is rst > load > step > hold.
module digit_counter #(
   parameter int unsigned DIV = 50000000,
   parameter int unsigned PW  = 26
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       up,
   input  logic       bcd,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic [3:0] digit0,
   output logic [3:0] digit1,
   output logic       tick,
   output logic       tc
);

   localparam logic [PW-1:0] PresMax = PW'(DIV - 1);

   logic [PW-1:0] presc_q, presc_d;
   logic [3:0]    digit0_q, digit0_d;
   logic [3:0]    digit1_q, digit1_d;
   logic          tick_q, tick_d;
   logic          tc_q, tc_d;

   logic          step;
   logic [7:0]    hex_val;
   logic [3:0]    b0, b1;
   logic [3:0]    nxt0, nxt1;
   logic          wrap;

   function automatic logic [3:0] clamp9(input logic [3:0] n);
      return (n > 4'd9) ? 4'd9 : n;
   endfunction

   assign step = en && (presc_q == PresMax);

   // Candidate digit values for a step; only committed when step wins priority.
   always_comb begin
      hex_val = {digit1_q, digit0_q};
      b0      = clamp9(digit0_q);
      b1      = clamp9(digit1_q);
      nxt0    = '0;
      nxt1    = '0;
      wrap    = 1'b0;
      if (!bcd) begin
         if (up) begin
            {nxt1, nxt0} = hex_val + 8'd1;
            wrap         = (hex_val == 8'hFF);
         end else begin
            {nxt1, nxt0} = hex_val - 8'd1;
            wrap         = (hex_val == 8'h00);
         end
      end else if (up) begin
         if (b0 == 4'd9) begin
            nxt0 = 4'd0;
            if (b1 == 4'd9) begin
               nxt1 = 4'd0;
               wrap = 1'b1;
            end else begin
               nxt1 = b1 + 4'd1;
            end
         end else begin
            nxt0 = b0 + 4'd1;
            nxt1 = b1;
         end
      end else begin
         if (b0 == 4'd0) begin
            nxt0 = 4'd9;
            if (b1 == 4'd0) begin
               nxt1 = 4'd9;
               wrap = 1'b1;
            end else begin
               nxt1 = b1 - 4'd1;
            end
         end else begin
            nxt0 = b0 - 4'd1;
            nxt1 = b1;
         end
      end
   end

   always_comb begin
      presc_d  = presc_q;
      digit0_d = digit0_q;
      digit1_d = digit1_q;
      tick_d   = 1'b0;
      tc_d     = 1'b0;
      if (load) begin
         presc_d  = '0;
         digit1_d = bcd ? clamp9(load_val[7:4]) : load_val[7:4];
         digit0_d = bcd ? clamp9(load_val[3:0]) : load_val[3:0];
      end else if (step) begin
         presc_d  = '0;
         digit0_d = nxt0;
         digit1_d = nxt1;
         tick_d   = 1'b1;
         tc_d     = wrap;
      end else if (en) begin
         presc_d = presc_q + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q  <= '0;
         digit0_q <= '0;
         digit1_q <= '0;
         tick_q   <= 1'b0;
         tc_q     <= 1'b0;
      end else begin
         presc_q  <= presc_d;
         digit0_q <= digit0_d;
         digit1_q <= digit1_d;
         tick_q   <= tick_d;
         tc_q     <= tc_d;
      end
   end

   assign digit0 = digit0_q;
   assign digit1 = digit1_q;
   assign tick   = tick_q;
   assign tc     = tc_q;

endmodule

// File: tb/tb_digit_counter.sv
// Bench for digit_counter: DIV=4 and DIV=1 instances share stimulus and are checked
// every cycle against an arithmetic model, plus directed literal expectations.
module tb_digit_counter;

   logic       clk = 1'b0;
   logic       rst, en, up, bcd, load;
   logic [7:0] load_val;
   logic [3:0] a_d0, a_d1, b_d0, b_d1;
   logic       a_tick, a_tc, b_tick, b_tc;

   int n_checks = 0;
   int n_errors = 0;

   // Model state, index 0 = DIV 4 instance, index 1 = DIV 1 instance.
   int m_d0[2];
   int m_d1[2];
   int m_pres[2];
   bit m_tick[2];
   bit m_tc[2];

   always #5 clk = ~clk;

   digit_counter #(.DIV(4), .PW(4)) u_dut_a (
      .clk(clk), .rst(rst), .en(en), .up(up), .bcd(bcd), .load(load),
      .load_val(load_val), .digit0(a_d0), .digit1(a_d1), .tick(a_tick), .tc(a_tc)
   );

   digit_counter #(.DIV(1), .PW(1)) u_dut_b (
      .clk(clk), .rst(rst), .en(en), .up(up), .bcd(bcd), .load(load),
      .load_val(load_val), .digit0(b_d0), .digit1(b_d1), .tick(b_tick), .tc(b_tc)
   );

   function automatic int min9(input int n);
      return (n > 9) ? 9 : n;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Counter treated as a number: 0..255 in hex, 0..99 in decimal.
   task automatic model_edge(input int k, input int div);
      int v;
      m_tick[k] = 1'b0;
      m_tc[k]   = 1'b0;
      if (rst) begin
         m_d0[k] = 0; m_d1[k] = 0; m_pres[k] = 0;
      end else if (load) begin
         m_pres[k] = 0;
         m_d1[k]   = int'(load_val[7:4]);
         m_d0[k]   = int'(load_val[3:0]);
         if (bcd) begin
            m_d1[k] = min9(m_d1[k]);
            m_d0[k] = min9(m_d0[k]);
         end
      end else if (en) begin
         if (m_pres[k] == div - 1) begin
            m_pres[k] = 0;
            m_tick[k] = 1'b1;
            if (bcd) begin
               v = min9(m_d1[k]) * 10 + min9(m_d0[k]);
               if (up) begin m_tc[k] = (v == 99); v = (v + 1) % 100; end
               else    begin m_tc[k] = (v == 0);  v = (v + 99) % 100; end
               m_d1[k] = v / 10;
               m_d0[k] = v % 10;
            end else begin
               v = m_d1[k] * 16 + m_d0[k];
               if (up) begin m_tc[k] = (v == 255); v = (v + 1) % 256; end
               else    begin m_tc[k] = (v == 0);   v = (v + 255) % 256; end
               m_d1[k] = v / 16;
               m_d0[k] = v % 16;
            end
         end else begin
            m_pres[k]++;
         end
      end
   endtask

   task automatic run(input int n);
      repeat (n) begin
         @(posedge clk);
         model_edge(0, 4);
         model_edge(1, 1);
         @(negedge clk);
         chk("model_digits_div4", {a_d1, a_d0}, 8'(m_d1[0] * 16 + m_d0[0]));
         chk1("model_tick_div4", a_tick, m_tick[0]);
         chk1("model_tc_div4", a_tc, m_tc[0]);
         chk("model_digits_div1", {b_d1, b_d0}, 8'(m_d1[1] * 16 + m_d0[1]));
         chk1("model_tick_div1", b_tick, m_tick[1]);
         chk1("model_tc_div1", b_tc, m_tc[1]);
      end
   endtask

   initial begin
      int nt, ntc;
      rst = 1'b1; en = 1'b0; up = 1'b1; bcd = 1'b0; load = 1'b0; load_val = 8'h00;
      run(1);
      chk("reset_digits", {a_d1, a_d0}, 8'h00);
      chk1("reset_tick", a_tick, 1'b0);
      chk1("reset_tc", a_tc, 1'b0);

      // Hex up from reset
      rst = 1'b0; en = 1'b1; up = 1'b1; bcd = 1'b0;
      nt = 0; ntc = 0;
      for (int i = 0; i < 8; i++) begin
         run(1);
         nt  += int'(a_tick);
         ntc += int'(a_tc);
         if (i == 2) chk("hex_up_before_step", {a_d1, a_d0}, 8'h00);
         if (i == 3) chk("hex_up_first_step", {a_d1, a_d0}, 8'h01);
      end
      chk("hex_up_second_step", {a_d1, a_d0}, 8'h02);
      chk("hex_up_tick_count", 8'(nt), 8'd2);
      chk("hex_up_tc_count", 8'(ntc), 8'd0);
      chk("div1_every_cycle", {b_d1, b_d0}, 8'h08);

      // BCD up wrap
      load = 1'b1; load_val = 8'h99; bcd = 1'b1; up = 1'b1;
      run(1);
      load = 1'b0;
      chk("bcd_load_99", {a_d1, a_d0}, 8'h99);
      run(3);
      chk1("bcd_wrap_no_tick_yet", a_tick, 1'b0);
      run(1);
      chk("bcd_wrap_digits", {a_d1, a_d0}, 8'h00);
      chk1("bcd_wrap_tick", a_tick, 1'b1);
      chk1("bcd_wrap_tc", a_tc, 1'b1);
      run(1);
      chk1("bcd_wrap_tc_one_cycle", a_tc, 1'b0);

      // Hex down wrap
      load = 1'b1; load_val = 8'h00; bcd = 1'b0; up = 1'b0;
      run(1);
      load = 1'b0;
      run(4);
      chk("hex_down_wrap", {a_d1, a_d0}, 8'hFF);
      chk1("hex_down_wrap_tc", a_tc, 1'b1);
      run(4);
      chk("hex_down_next", {a_d1, a_d0}, 8'hFE);
      chk1("hex_down_next_tick", a_tick, 1'b1);
      chk1("hex_down_next_tc", a_tc, 1'b0);

      // BCD borrow and load clamp
      load = 1'b1; load_val = 8'h10; bcd = 1'b1; up = 1'b0;
      run(1);
      load = 1'b0;
      run(4);
      chk("bcd_borrow", {a_d1, a_d0}, 8'h09);
      load = 1'b1; load_val = 8'hAF;
      run(1);
      load = 1'b0;
      chk("bcd_load_clamp", {a_d1, a_d0}, 8'h99);

      // Raw hex load, then switch to BCD: mode edge must not move digits, step clamps
      load = 1'b1; load_val = 8'h3C; bcd = 1'b0; up = 1'b1;
      run(1);
      load = 1'b0; bcd = 1'b1;
      run(1);
      chk("mode_edge_hold", {a_d1, a_d0}, 8'h3C);
      run(3);
      chk("bcd_step_clamp_up", {a_d1, a_d0}, 8'h40);

      // Enable hold and reset mid-count
      rst = 1'b1;
      run(1);
      rst = 1'b0; en = 1'b1; up = 1'b1; bcd = 1'b0;
      run(2);
      en = 1'b0;
      nt = 0;
      for (int i = 0; i < 10; i++) begin
         run(1);
         nt += int'(a_tick);
      end
      chk("hold_digits", {a_d1, a_d0}, 8'h00);
      chk("hold_no_tick", 8'(nt), 8'd0);
      en = 1'b1;
      run(1);
      chk("hold_resume_no_step", {a_d1, a_d0}, 8'h00);
      rst = 1'b1;
      run(1);
      chk("mid_reset_digits", {a_d1, a_d0}, 8'h00);
      rst = 1'b0;
      run(3);
      chk1("post_reset_no_early_step", a_tick, 1'b0);
      run(1);
      chk("post_reset_first_step", {a_d1, a_d0}, 8'h01);
      chk1("post_reset_tick", a_tick, 1'b1);

      // Load colliding with a step
      rst = 1'b1;
      run(1);
      rst = 1'b0; en = 1'b1;
      run(3);
      load = 1'b1; load_val = 8'h42;
      run(1);
      load = 1'b0;
      chk("collide_digits", {a_d1, a_d0}, 8'h42);
      chk1("collide_tick", a_tick, 1'b0);
      chk1("collide_tc", a_tc, 1'b0);
      chk("collide_div1_digits", {b_d1, b_d0}, 8'h42);
      chk1("collide_div1_tick", b_tick, 1'b0);
      run(3);
      chk("collide_presc_cleared", {a_d1, a_d0}, 8'h42);
      run(1);
      chk("collide_next_step", {a_d1, a_d0}, 8'h43);

      // Randomized traffic, checked by the model every cycle
      for (int i = 0; i < 4000; i++) begin
         rst  = ($urandom_range(0, 99) == 0);
         load = ($urandom_range(0, 15) == 0);
         case ($urandom_range(0, 5))
            0: load_val = 8'h00;
            1: load_val = 8'h99;
            2: load_val = 8'hFF;
            3: load_val = 8'h90;
            4: load_val = 8'h09;
            default: load_val = 8'($urandom);
         endcase
         en = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 31) == 0) up = ~up;
         if ($urandom_range(0, 31) == 0) bcd = ~bcd;
         run(1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
